// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared Game of Life constants and types. Grid geometry,
//                generation-sequencer state encoding and the bank selector
//                type used by the sequencer, display and frame memory logic.
//  Revision    : 1.0  initial release
// ============================================================================
package gol_pkg;

  localparam int WIDTH  = 640;  // grid columns
  localparam int HEIGHT = 480;  // grid rows
  localparam int ROW_W  = 9;    // row index width, 2**ROW_W >= HEIGHT

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SWEEP       = 3'd1,
    DRAIN       = 3'd2,
    WAIT_VBLANK = 3'd3,
    SWAP        = 3'd4,
    PACE        = 3'd5
  } seq_state_t;

  typedef logic bank_t;

endpackage
`default_nettype wire

// File: rtl/gol_generation_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gol_generation_sequencer_if
//  Description : Read-slot handshake between the generation sequencer, the
//                frame-memory arbiter and the row engine write strobe.
//  Ports       : rd_req   - read slot request (sequencer -> arbiter)
//                rd_row   - row to read
//                rd_flush - slot is a zero pad row, no memory access
//                rd_gnt   - arbiter accepts the slot this cycle
//                wr_valid - engine produced a next-generation row
//  Revision    : 1.0  initial release
// ============================================================================
interface gol_generation_sequencer_if #(
  parameter int ROW_W = gol_pkg::ROW_W
);
  logic             rd_req;
  logic [ROW_W-1:0] rd_row;
  logic             rd_flush;
  logic             rd_gnt;
  logic             wr_valid;

  modport master (
    output rd_req, rd_row, rd_flush,
    input  rd_gnt, wr_valid
  );

  modport slave (
    input  rd_req, rd_row, rd_flush,
    output rd_gnt, wr_valid
  );
endinterface
`default_nettype wire

// File: rtl/gol_vblank_edge.sv
`default_nettype none
// ============================================================================
//  Module      : gol_vblank_edge
//  Description : Registers the vblank level and flags its rising edge.
//                Shared with the display timing logic.
//  Ports       : clk, reset (async, active-high)
//                vblank - vertical blank level
//                rise   - high while vblank=1 and last registered value=0
//  Revision    : 1.0  initial release
// ============================================================================
module gol_vblank_edge (
  input  logic clk,
  input  logic reset,
  input  logic vblank,
  output logic rise
);

  logic vblank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign rise = vblank & ~vblank_q;

endmodule
`default_nettype wire

// File: rtl/gol_generation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gol_generation_sequencer
//  Description : Runs one Game of Life generation at a time through the row
//                engine using ping-pong banks. Rows are read from the
//                displayed bank, results land in the other bank, and the
//                banks swap on a vblank rising edge. Supports continuous run,
//                single step, stop and a vblank-based rate divider.
//  Ports       : clk, reset (async, active-high)
//                run/step/stop   - host control (level / pulse / pulse)
//                rate_div        - extra vblanks between generations in run
//                vblank          - display vertical blank level
//                rd_bus          - read slot handshake + engine write strobe
//                src/dst/disp_bank, busy, gen_done, gen_count - status
//  Revision    : 1.0  initial release
// ============================================================================
module gol_generation_sequencer #(
  parameter int WIDTH  = gol_pkg::WIDTH,
  parameter int HEIGHT = gol_pkg::HEIGHT,
  parameter int ROW_W  = gol_pkg::ROW_W,
  parameter int GEN_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       step,
  input  logic                       stop,
  input  logic [7:0]                 rate_div,
  input  logic                       vblank,
  gol_generation_sequencer_if.master rd_bus,
  output logic                       src_bank,
  output logic                       dst_bank,
  output logic                       disp_bank,
  output logic                       busy,
  output logic                       gen_done,
  output logic [GEN_W-1:0]           gen_count
);
  import gol_pkg::*;

  localparam logic [ROW_W:0] LAST = (ROW_W+1)'(HEIGHT);
  localparam logic [ROW_W:0] ONE  = (ROW_W+1)'(1);

  generate
    if (WIDTH < 1 || (2**ROW_W) < HEIGHT || HEIGHT < 1) begin : g_bad_params
      $error("gol_generation_sequencer: invalid WIDTH/HEIGHT/ROW_W");
    end
  endgenerate

  seq_state_t       state;
  bank_t            disp_q;
  logic             rd_req_q;
  logic             rd_flush_q;
  logic [ROW_W-1:0] rd_row_q;
  // One extra bit so the counters can hold HEIGHT itself.
  logic [ROW_W:0]   rd_cnt;
  logic [ROW_W:0]   wr_cnt;
  logic [ROW_W:0]   rd_next;
  logic [ROW_W:0]   wr_next;
  logic [7:0]       vb_cnt;
  logic             stop_pending;
  logic             vb_rise;
  logic             write_done;

  gol_vblank_edge u_vblank_edge (
    .clk    (clk),
    .reset  (reset),
    .vblank (vblank),
    .rise   (vb_rise)
  );

  assign rd_next    = rd_cnt + ONE;
  assign wr_next    = wr_cnt + ONE;
  assign write_done = rd_bus.wr_valid && (wr_next == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      disp_q       <= 1'b0;
      gen_count    <= '0;
      gen_done     <= 1'b0;
      busy         <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_flush_q   <= 1'b0;
      rd_row_q     <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      vb_cnt       <= '0;
      stop_pending <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      if (stop && state != IDLE) stop_pending <= 1'b1;

      case (state)
        IDLE: begin
          // A step overrides a coincident stop, so stop_pending stays clear.
          if (step || run) begin
            state        <= SWEEP;
            busy         <= 1'b1;
            rd_req_q     <= 1'b1;
            rd_flush_q   <= 1'b0;
            rd_row_q     <= '0;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            stop_pending <= 1'b0;
          end
        end

        SWEEP, DRAIN: begin
          // Slot contents only advance on a grant, so they stay stable
          // while the arbiter stalls.
          if (state == SWEEP && rd_bus.rd_gnt) begin
            if (rd_flush_q) begin
              rd_req_q   <= 1'b0;
              rd_flush_q <= 1'b0;
              state      <= DRAIN;
            end else begin
              rd_cnt <= rd_next;
              if (rd_next == LAST) begin
                rd_flush_q <= 1'b1;
                rd_row_q   <= '0;
              end else begin
                rd_row_q <= rd_next[ROW_W-1:0];
              end
            end
          end
          if (rd_bus.wr_valid) begin
            wr_cnt <= wr_next;
          end
          // Last engine row may coincide with the flush grant; this wins.
          if (write_done) begin
            state      <= WAIT_VBLANK;
            rd_req_q   <= 1'b0;
            rd_flush_q <= 1'b0;
          end
        end

        WAIT_VBLANK: begin
          if (vb_rise) state <= SWAP;
        end

        SWAP: begin
          disp_q    <= ~disp_q;
          gen_count <= gen_count + GEN_W'(1);
          gen_done  <= 1'b1;
          vb_cnt    <= rate_div;
          // A stop arriving in this very cycle is honoured here.
          if (run && !stop_pending && !stop) begin
            state <= PACE;
          end else begin
            state        <= IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end
        end

        PACE: begin
          if (!run || stop_pending || stop) begin
            state        <= IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end else if (vb_cnt == 8'd0) begin
            state      <= SWEEP;
            rd_req_q   <= 1'b1;
            rd_flush_q <= 1'b0;
            rd_row_q   <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
          end else if (vb_rise) begin
            vb_cnt <= vb_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_bus.rd_req   = rd_req_q;
  assign rd_bus.rd_row   = rd_row_q;
  assign rd_bus.rd_flush = rd_flush_q;
  assign disp_bank       = disp_q;
  assign src_bank        = disp_q;
  assign dst_bank        = ~disp_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_generation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_generation_sequencer
//  Description : Directed self-checking bench for gol_generation_sequencer
//                with an 8-row grid and a 4-bit generation counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gol_generation_sequencer;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic       stop;
  logic       vblank;
  logic [7:0] rate_div;
  logic       src_bank;
  logic       dst_bank;
  logic       disp_bank;
  logic       busy;
  logic       gen_done;
  logic [3:0] gen_count;

  gol_generation_sequencer_if #(.ROW_W(3)) bus ();

  gol_generation_sequencer #(
    .HEIGHT (H),
    .ROW_W  (3),
    .GEN_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .stop      (stop),
    .rate_div  (rate_div),
    .vblank    (vblank),
    .rd_bus    (bus),
    .src_bank  (src_bank),
    .dst_bank  (dst_bank),
    .disp_bank (disp_bank),
    .busy      (busy),
    .gen_done  (gen_done),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Grant log, gen_done count and the row engine model.
  int log_n = 0;
  int log_row [0:1023];
  bit log_flush [0:1023];
  int gd_n = 0;
  int eng_cnt = 0;
  bit wv;
  int exp_count = 0;
  bit exp_disp = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      eng_cnt = 0;
      wv = 1'b0;
    end else if (bus.rd_req && bus.rd_gnt) begin
      if (log_n < 1024) begin
        log_row[log_n]   = int'(bus.rd_row);
        log_flush[log_n] = bus.rd_flush;
      end
      log_n++;
      // Row k leaves the engine once row k+1 (or the flush slot) arrived.
      wv = (eng_cnt != 0);
      eng_cnt = bus.rd_flush ? 0 : eng_cnt + 1;
    end else begin
      wv = 1'b0;
    end
    if (!reset && gen_done) gd_n++;
    #1 bus.wr_valid = wv;
  end

  task automatic wait_grants(input int target, input int budget, output bit ok);
    int c = 0;
    while (log_n < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (log_n >= target);
  endtask

  task automatic vblank_pulse(input int hi, input int lo);
    @(negedge clk) vblank = 1'b1;
    repeat (hi) @(negedge clk);
    vblank = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic run_one_gen(output bit ok);
    int base = log_n;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    wait_grants(base + H + 1, 60, ok);
    repeat (5) @(negedge clk);
    vblank_pulse(3, 5);
    exp_count = (exp_count + 1) % 16;
    exp_disp  = ~exp_disp;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; step = 1'b0; stop = 1'b0; vblank = 1'b0;
    rate_div = 8'd0; bus.rd_gnt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.rd_req !== 1'b0 || bus.rd_flush !== 1'b0 || gen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rd_req=%b rd_flush=%b gen_done=%b, want all 0",
               busy, bus.rd_req, bus.rd_flush, gen_done);
    end
    checks++;
    if (disp_bank !== 1'b0 || gen_count !== 4'd0 || bus.rd_row !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: disp=%b count=%0d row=%0d, want 0 0 0",
               disp_bank, gen_count, bus.rd_row);
    end
    checks++;
    if (src_bank !== 1'b0 || dst_bank !== 1'b1) begin
      errors++;
      $display("FAIL reset_banks: src=%b dst=%b, want 0 1", src_bank, dst_bank);
    end
  endtask

  task automatic test_step;
    int base = log_n;
    int gd0 = gd_n;
    bit ok;
    bus.rd_gnt = 1'b1;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    checks++;
    if (bus.rd_req !== 1'b1 || bus.rd_row !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL step_latency: rd_req=%b row=%0d busy=%b, want 1 0 1",
               bus.rd_req, bus.rd_row, busy);
    end
    wait_grants(base + H + 1, 40, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || log_n - base != H + 1) begin
      errors++;
      $display("FAIL step_grants: got %0d grants, want %0d", log_n - base, H + 1);
    end
    for (int i = 0; i <= H; i++) begin
      checks++;
      if (log_row[base+i] != ((i < H) ? i : 0) || log_flush[base+i] != (i == H)) begin
        errors++;
        $display("FAIL step_seq[%0d]: row=%0d flush=%0b, want row=%0d flush=%0b",
                 i, log_row[base+i], log_flush[base+i], (i < H) ? i : 0, (i == H));
      end
    end
    checks++;
    if (gen_count !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL step_prevblank: count=%0d busy=%b, want 0 1", gen_count, busy);
    end
    vblank_pulse(3, 6);
    exp_count = 1; exp_disp = 1'b1;
    checks++;
    if (gen_count !== 4'd1 || disp_bank !== 1'b1 || src_bank !== 1'b1 || dst_bank !== 1'b0) begin
      errors++;
      $display("FAIL step_swap: count=%0d disp=%b src=%b dst=%b, want 1 1 1 0",
               gen_count, disp_bank, src_bank, dst_bank);
    end
    checks++;
    if (gd_n - gd0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL step_done: gen_done pulses=%0d busy=%b, want 1 0", gd_n - gd0, busy);
    end
  endtask

  task automatic test_rate;
    int exp_inc;
    int base_count = exp_count;
    bus.rd_gnt = 1'b1;
    rate_div = 8'd2;
    @(negedge clk) run = 1'b1;
    repeat (30) @(negedge clk);
    for (int e = 1; e <= 7; e++) begin
      vblank_pulse(5, 35);
      exp_inc = (e + 2) / 3;  // swaps on edges 1, 4, 7
      checks++;
      if (gen_count !== 4'((base_count + exp_inc) % 16)) begin
        errors++;
        $display("FAIL rate_count edge %0d: count=%0d, want %0d",
                 e, gen_count, (base_count + exp_inc) % 16);
      end
      checks++;
      if (src_bank === dst_bank || src_bank !== disp_bank) begin
        errors++;
        $display("FAIL rate_banks edge %0d: src=%b dst=%b disp=%b", e, src_bank, dst_bank, disp_bank);
      end
    end
    exp_count = (base_count + 3) % 16;
    exp_disp  = ~exp_disp;
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || disp_bank !== exp_disp) begin
      errors++;
      $display("FAIL rate_idle: busy=%b disp=%b, want 0 %b", busy, disp_bank, exp_disp);
    end
    rate_div = 8'd0;
  endtask

  task automatic test_random_grant;
    int base = log_n;
    bit prev_req = 1'b0;
    bit prev_gnt = 1'b0;
    logic [2:0] prev_row = '0;
    bit prev_flush = 1'b0;
    int c = 0;
    bus.rd_gnt = 1'b0;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    while (log_n < base + H + 1 && c < 400) begin
      if (prev_req && !prev_gnt) begin
        checks++;
        if (bus.rd_req !== 1'b1 || bus.rd_row !== prev_row || bus.rd_flush !== prev_flush) begin
          errors++;
          $display("FAIL stall_stable: req=%b row=%0d flush=%b, want 1 %0d %b",
                   bus.rd_req, bus.rd_row, bus.rd_flush, prev_row, prev_flush);
        end
      end
      prev_req   = bus.rd_req;
      prev_row   = bus.rd_row;
      prev_flush = bus.rd_flush;
      bus.rd_gnt = ($urandom_range(0, 99) < 30);
      prev_gnt   = bus.rd_gnt;
      @(negedge clk);
      c++;
    end
    bus.rd_gnt = 1'b1;
    checks++;
    if (log_n - base != H + 1) begin
      errors++;
      $display("FAIL random_grants: got %0d grants, want %0d", log_n - base, H + 1);
    end
    for (int i = 0; i <= H; i++) begin
      checks++;
      if (log_row[base+i] != ((i < H) ? i : 0) || log_flush[base+i] != (i == H)) begin
        errors++;
        $display("FAIL random_seq[%0d]: row=%0d flush=%0b, want row=%0d flush=%0b",
                 i, log_row[base+i], log_flush[base+i], (i < H) ? i : 0, (i == H));
      end
    end
    repeat (5) @(negedge clk);
    vblank_pulse(3, 6);
    exp_count = (exp_count + 1) % 16;
    exp_disp  = ~exp_disp;
    checks++;
    if (gen_count !== 4'(exp_count) || disp_bank !== exp_disp) begin
      errors++;
      $display("FAIL random_swap: count=%0d disp=%b, want %0d %b",
               gen_count, disp_bank, exp_count, exp_disp);
    end
  endtask

  task automatic test_stop;
    int base = log_n;
    int gd0 = gd_n;
    int after;
    bit ok;
    bus.rd_gnt = 1'b1;
    rate_div = 8'd0;
    @(negedge clk) run = 1'b1;
    wait_grants(base + 4, 20, ok);
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    step = 1'b1;
    @(negedge clk) step = 1'b0;
    wait_grants(base + H + 1, 40, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || log_n - base != H + 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_sweep: grants=%0d busy=%b, want %0d 1", log_n - base, busy, H + 1);
    end
    vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_count = (exp_count + 1) % 16;
    exp_disp  = ~exp_disp;
    checks++;
    if (busy !== 1'b0 || gen_done !== 1'b1 || gen_count !== 4'(exp_count)) begin
      errors++;
      $display("FAIL stop_idle: busy=%b gen_done=%b count=%0d, want 0 1 %0d",
               busy, gen_done, gen_count, exp_count);
    end
    run = 1'b0;
    vblank = 1'b0;
    after = log_n;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_n != after || gen_count !== 4'(exp_count) || gd_n - gd0 != 1) begin
      errors++;
      $display("FAIL stop_stays: busy=%b new_grants=%0d count=%0d pulses=%0d, want 0 0 %0d 1",
               busy, log_n - after, gen_count, exp_count, gd_n - gd0);
    end
  endtask

  task automatic test_reset_mid;
    int base = log_n;
    bit ok;
    bus.rd_gnt = 1'b1;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    wait_grants(base + 6, 20, ok);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || disp_bank !== 1'b0 || gen_count !== 4'd0 || bus.rd_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset: busy=%b disp=%b count=%0d rd_req=%b, want 0 0 0 0",
               busy, disp_bank, gen_count, bus.rd_req);
    end
    reset = 1'b0;
    exp_count = 0;
    exp_disp  = 1'b0;
    @(negedge clk);
    base = log_n;
    run_one_gen(ok);
    checks++;
    if (!ok || log_n - base != H + 1) begin
      errors++;
      $display("FAIL midreset_grants: got %0d grants, want %0d", log_n - base, H + 1);
    end
    for (int i = 0; i <= H; i++) begin
      checks++;
      if (log_row[base+i] != ((i < H) ? i : 0) || log_flush[base+i] != (i == H)) begin
        errors++;
        $display("FAIL midreset_seq[%0d]: row=%0d flush=%0b, want row=%0d flush=%0b",
                 i, log_row[base+i], log_flush[base+i], (i < H) ? i : 0, (i == H));
      end
    end
    checks++;
    if (gen_count !== 4'd1 || disp_bank !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_gen: count=%0d disp=%b busy=%b, want 1 1 0", gen_count, disp_bank, busy);
    end
  endtask

  task automatic test_vblank_high;
    int base = log_n;
    bit ok;
    bus.rd_gnt = 1'b1;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    wait_grants(base + 4, 20, ok);
    vblank = 1'b1;  // rises during the sweep, stays high into the vblank wait
    wait_grants(base + H + 1, 40, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (gen_count !== 4'(exp_count) || busy !== 1'b1) begin
      errors++;
      $display("FAIL vblank_high_noswap: count=%0d busy=%b, want %0d 1", gen_count, busy, exp_count);
    end
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    exp_count = (exp_count + 1) % 16;
    exp_disp  = ~exp_disp;
    checks++;
    if (gen_count !== 4'(exp_count) || disp_bank !== exp_disp || busy !== 1'b0) begin
      errors++;
      $display("FAIL vblank_high_swap: count=%0d disp=%b busy=%b, want %0d %b 0",
               gen_count, disp_bank, busy, exp_count, exp_disp);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    bit all_ok = 1'b1;
    int n = 0;
    while (exp_count != 15 && n < 20) begin
      run_one_gen(ok);
      all_ok &= ok;
      n++;
    end
    checks++;
    if (!all_ok || gen_count !== 4'hF) begin
      errors++;
      $display("FAIL wrap_pre: count=%0d grants_ok=%b, want 15 1", gen_count, all_ok);
    end
    run_one_gen(ok);
    checks++;
    if (!ok || gen_count !== 4'h0 || disp_bank !== exp_disp) begin
      errors++;
      $display("FAIL wrap: count=%0d disp=%b, want 0 %b", gen_count, disp_bank, exp_disp);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_rate();
    test_random_grant();
    test_stop();
    test_reset_mid();
    test_vblank_high();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gol_generation_sequencer.md
Name: gol_generation_sequencer

Overview:
Sequences one Game of Life generation at a time through the row-streaming GoL update engine using two ping-pong grid banks: read rows from the source bank, write next-generation rows to the destination bank, then swap banks on vertical blank so the display never shows a half-updated frame. Sits between the host/button control logic, the frame-memory arbiter and the row engine. Supports continuous run, single step and a generation-rate divider.

Parameters:
WIDTH, 640, grid columns; informational only, passed to the shared package
HEIGHT, 480, grid rows; sets the sweep length
ROW_W, 9, row index width; must satisfy 2^ROW_W >= HEIGHT
GEN_W, 16, generation counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
run  in  1  level; 1 = continuous generations
step  in  1  pulse; request exactly one generation, honoured only in IDLE
stop  in  1  pulse; finish the current generation, then go to IDLE
rate_div  in  8  extra vblanks to wait between generations in run mode
vblank  in  1  display vertical-blank level
rd_req  out  1  read request to the memory arbiter
rd_row  out  ROW_W  row to read
rd_flush  out  1  qualifies a read slot as a zero pad row with no memory access
rd_gnt  in  1  arbiter accepts the read slot this cycle
wr_valid  in  1  engine has produced a next-generation row this cycle
src_bank  out  1  bank being read; equals disp_bank
dst_bank  out  1  bank being written; always the inverse of src_bank
disp_bank  out  1  bank shown by the display
busy  out  1  high in every state except IDLE
gen_done  out  1  one-cycle pulse on swap
gen_count  out  GEN_W  number of completed generations

Behaviour:
- Reset values:
  - state = IDLE; disp_bank = 0; gen_count = 0.
  - rd_req, rd_flush, gen_done and busy all = 0.
  - rd_row = 0; internal read and write counters = 0; vblank-wait counter = 0; stop_pending = 0.
- A reset asserted mid-sweep aborts immediately. A partially written destination bank is harmless because it is never displayed.
- IDLE:
  - Leave when run=1, or when a step pulse arrives; go to SWEEP and clear the read and write counters.
  - step has priority over nothing else; a step pulse in any other state is ignored.
- SWEEP:
  - Hold rd_req=1 with rd_row = read counter.
  - On each cycle with rd_req && rd_gnt, increment the read counter.
  - Once the read counter reaches HEIGHT, present one final slot with rd_flush=1 (rd_row = 0). When that slot is granted, drop rd_req and go to DRAIN.
  - The request stays asserted until granted; rd_row and rd_flush must not change while the slot is ungranted.
- Write tracking:
  - In SWEEP and DRAIN, each wr_valid increments the write counter.
  - The engine emits row k after receiving row k+1 or the flush slot.
  - When the write counter reaches HEIGHT, go to WAIT_VBLANK. This can happen directly from SWEEP if wr_valid coincides with the flush grant.
  - wr_valid outside SWEEP/DRAIN is ignored.
- WAIT_VBLANK: wait for the rising edge of vblank (registered previous value = 0, current value = 1). A vblank already high on entry does not count.
- SWAP (one cycle):
  - Toggle disp_bank; increment gen_count (wraps modulo 2^GEN_W).
  - Pulse gen_done.
  - Load the vblank-wait counter with rate_div.
  - Next state: PACE if run=1 and stop_pending=0; otherwise IDLE, clearing stop_pending.
- PACE:
  - Each vblank rising edge decrements the counter.
  - When the counter is 0 and run=1 and stop_pending=0, go to SWEEP.
  - If run has dropped or stop_pending is set, go to IDLE.
  - rate_div = 0 means the next sweep starts on the cycle after SWAP.
- stop:
  - A stop pulse in any non-IDLE state sets stop_pending.
  - A stop in IDLE is a no-op.
  - Deasserting run mid-sweep also completes the current generation; it never aborts a sweep.
- Simultaneous events:
  - stop together with step in IDLE: step wins, one generation runs, and stop is dropped.
  - stop coinciding with SWAP: takes effect in that same SWAP cycle.
- Latency: from step to first rd_req is 1 cycle. For a stall-free arbiter, the minimum generation time is HEIGHT+1 read cycles, plus engine drain, plus the wait for vblank.

Decomposition:
- Package gol_pkg holds:
  - WIDTH, HEIGHT and ROW_W constants.
  - seq_state_t enum: IDLE, SWEEP, DRAIN, WAIT_VBLANK, SWAP, PACE.
  - bank_t typedef.
- One natural sub-module, gol_vblank_edge: registers vblank and outputs a rising-edge pulse. It is shared with the display timing logic.

Test Plan:
- Reset, then one step with rd_gnt tied to 1 and an engine model that emits wr_valid one cycle after each grant from the second onward → exactly HEIGHT+1 grants (rows 0..HEIGHT-1, then flush); after the next vblank edge, gen_count=1, disp_bank=1 and one gen_done pulse; then IDLE.
- run=1, rate_div=2, vblank every 1000 cycles, HEIGHT=8 → swaps on every third vblank edge; gen_count increments 1, 2, 3; src_bank and dst_bank always complementary.
- rd_gnt random at 30% → rd_row and rd_flush stay stable while ungranted; no row is skipped or repeated; the row sequence is 0..HEIGHT-1 followed by flush.
- stop pulse at row 3 of a run-mode sweep → the sweep completes, exactly one swap occurs, then IDLE with busy=0; a step pulse during the sweep is ignored.
- Reset asserted at row 5 → next cycle shows IDLE, disp_bank=0, gen_count=0, rd_req=0; a following step runs cleanly from row 0.
- vblank already high when WAIT_VBLANK is entered → no swap until the next rising edge; gen_count=0xFFFF followed by one more generation wraps to 0.
